// File: rtl/enc_pkg.sv
// Shared types and constants for the MIPS32 instruction encoder.
// Build option: ENC_DELAY_SLOT_NOP_EN (see enc_word_gen).
package enc_pkg;

   typedef enum logic [3:0] {
      K_R    = 4'd0,
      K_I    = 4'd1,
      K_LI   = 4'd2,
      K_BR   = 4'd3,
      K_J    = 4'd4,
      K_MFC0 = 4'd5,
      K_MTC0 = 4'd6,
      K_ERET = 4'd7,
      K_TLB  = 4'd8
   } enc_kind_t;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_COP0    = 6'h10;

   localparam logic [4:0] CO_MF = 5'h00;
   localparam logic [4:0] CO_MT = 5'h04;

   localparam logic [31:0] ERET_WORD = 32'h42000018;
   localparam logic [31:0] NOP_WORD  = 32'h00000000;

   // Kind is kept raw so unknown codes survive
   // into the word generator and raise enc_err.
   typedef struct packed {
      logic [3:0]  kind;
      logic [5:0]  fn;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [31:0] imm;
   } enc_cmd_t;

   // A 32-bit constant needs lui+ori only when
   // both halves carry set bits.
   function automatic logic li_split(
      input logic [31:0] imm
   );
      return (imm[31:16] != 16'd0) &&
             (imm[15:0]  != 16'd0);
   endfunction

endpackage

// File: rtl/enc_word_gen.sv
// Combinational word generator: (command, word index) -> {data, last}.
// ENC_DELAY_SLOT_NOP_EN: branches/jumps get a trailing nop word.
module enc_word_gen
   import enc_pkg::*;
(
   input  enc_cmd_t    cmd,
   input  logic        idx,
   output logic [31:0] data,
   output logic        last,
   output logic        bad
);

   logic [15:0] hi;
   logic [15:0] lo;
   logic        two;
   logic [31:0] w0;
   logic [31:0] w1;

   // Build both candidate words, then pick by index
   always_comb begin
      hi  = cmd.imm[31:16];
      lo  = cmd.imm[15:0];
      two = 1'b0;
      w0  = NOP_WORD;
      w1  = NOP_WORD;
      bad = 1'b0;
      unique case (1'b1)
         (cmd.kind == K_R): begin
            w0 = {OP_SPECIAL, cmd.rs, cmd.rt,
                  cmd.rd, cmd.shamt, cmd.fn};
         end
         (cmd.kind == K_I): begin
            w0 = {cmd.fn, cmd.rs, cmd.rt, lo};
         end
         (cmd.kind == K_LI): begin
            if (li_split(cmd.imm)) begin
               two = 1'b1;
               w0  = {OP_LUI, 5'd0, cmd.rt, hi};
               w1  = {OP_ORI, cmd.rt, cmd.rt, lo};
            end else if (hi == 16'd0) begin
               w0 = {OP_ORI, 5'd0, cmd.rt, lo};
            end else begin
               w0 = {OP_LUI, 5'd0, cmd.rt, hi};
            end
         end
         (cmd.kind == K_BR): begin
            w0 = {cmd.fn, cmd.rs, cmd.rt, lo};
`ifdef ENC_DELAY_SLOT_NOP_EN
            two = 1'b1;
`else
            two = 1'b0;
`endif
         end
         (cmd.kind == K_J): begin
            w0 = {cmd.fn, cmd.imm[25:0]};
`ifdef ENC_DELAY_SLOT_NOP_EN
            two = 1'b1;
`else
            two = 1'b0;
`endif
         end
         (cmd.kind == K_MFC0): begin
            w0 = {OP_COP0, CO_MF, cmd.rt,
                  cmd.rd, 8'h00, cmd.imm[2:0]};
         end
         (cmd.kind == K_MTC0): begin
            w0 = {OP_COP0, CO_MT, cmd.rt,
                  cmd.rd, 8'h00, cmd.imm[2:0]};
         end
         (cmd.kind == K_ERET): begin
            w0 = ERET_WORD;
         end
         (cmd.kind == K_TLB): begin
            w0 = {OP_COP0, 1'b1, 19'd0, cmd.fn};
         end
         default: begin
            bad = 1'b1;
         end
      endcase
      data = idx ? w1 : w0;
      last = idx | ~two;
   end

endmodule

// File: rtl/mips_instr_encoder.sv
// Sequential MIPS32 encoder: command handshake in, word stream out.
// Build option: ENC_DELAY_SLOT_NOP_EN (branch/jump delay-slot nop).
module mips_instr_encoder
   import enc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_kind,
   input  logic [5:0]  cmd_fn,
   input  logic [4:0]  cmd_rs,
   input  logic [4:0]  cmd_rt,
   input  logic [4:0]  cmd_rd,
   input  logic [4:0]  cmd_shamt,
   input  logic [31:0] cmd_imm,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic        instr_last,
   output logic        enc_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] W0   = 2'd1;
   localparam logic [1:0] W1   = 2'd2;

   logic [1:0]  state_q;
   enc_cmd_t    cmd_q;
   enc_cmd_t    cmd_in;
   enc_cmd_t    gen_cmd;
   logic        gen_idx;
   logic [31:0] gen_data;
   logic        gen_last;
   logic        gen_bad;
   logic        out_fire;
   logic        accept;

   assign cmd_in = '{
      kind:  cmd_kind,
      fn:    cmd_fn,
      rs:    cmd_rs,
      rt:    cmd_rt,
      rd:    cmd_rd,
      shamt: cmd_shamt,
      imm:   cmd_imm
   };

   assign out_fire  = instr_valid & instr_ready;
   assign cmd_ready = (state_q == IDLE) |
                      (out_fire & instr_last);
   assign accept    = cmd_valid & cmd_ready;

   // A new command feeds word 0 straight to the
   // output register; otherwise step the held one.
   always_comb begin
      gen_cmd = cmd_q;
      gen_idx = 1'b1;
      if (accept) begin
         gen_cmd = cmd_in;
         gen_idx = 1'b0;
      end
   end

   enc_word_gen u_gen (
      .cmd  (gen_cmd),
      .idx  (gen_idx),
      .data (gen_data),
      .last (gen_last),
      .bad  (gen_bad)
   );

   // FSM and output register: load on accept,
   // advance or retire on word accept, else hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         instr_valid <= 1'b0;
         instr_data  <= '0;
         instr_last  <= 1'b0;
      end else if (accept) begin
         state_q     <= W0;
         cmd_q       <= cmd_in;
         instr_valid <= 1'b1;
         instr_data  <= gen_data;
         instr_last  <= gen_last;
      end else if (out_fire) begin
         if (instr_last) begin
            state_q     <= IDLE;
            instr_valid <= 1'b0;
         end else begin
            state_q    <= W1;
            instr_data <= gen_data;
            instr_last <= gen_last;
         end
      end
   end

   // Sticky error: any accepted unknown kind
   always_ff @(posedge clk) begin
      if (reset) begin
         enc_err <= 1'b0;
      end else if (accept && gen_bad) begin
         enc_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized self-checking bench for mips_instr_encoder.
// Reference model expands each accepted command into a word queue.
module tb_mips_instr_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_kind = '0;
   logic [5:0]  cmd_fn = '0;
   logic [4:0]  cmd_rs = '0;
   logic [4:0]  cmd_rt = '0;
   logic [4:0]  cmd_rd = '0;
   logic [4:0]  cmd_shamt = '0;
   logic [31:0] cmd_imm = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_data;
   logic        instr_last;
   logic        enc_err;

   int total = 0;
   int bad   = 0;

   logic [32:0] expq[$];
   logic        m_err = 1'b0;
   logic        held = 1'b0;
   logic [31:0] held_d = '0;
   logic        held_l = 1'b0;
   logic        acc = 1'b0;

   always #5 clk = ~clk;

   mips_instr_encoder dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_kind    (cmd_kind),
      .cmd_fn      (cmd_fn),
      .cmd_rs      (cmd_rs),
      .cmd_rt      (cmd_rt),
      .cmd_rd      (cmd_rd),
      .cmd_shamt   (cmd_shamt),
      .cmd_imm     (cmd_imm),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_data  (instr_data),
      .instr_last  (instr_last),
      .enc_err     (enc_err)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic push_word(input logic [31:0] d,
                            input logic l);
      expq.push_back({l, d});
   endtask

   // Expected word list of one command, from the
   // field-placement rules using shifts and adds.
   task automatic model_cmd(input logic [3:0] k,
                            input logic [5:0] fn_i,
                            input logic [4:0] rs_i,
                            input logic [4:0] rt_i,
                            input logic [4:0] rd_i,
                            input logic [4:0] sh_i,
                            input logic [31:0] imm);
      int unsigned fn, rs, rt, rd, sh, hi, lo, w;
      fn = 32'(fn_i);
      rs = 32'(rs_i);
      rt = 32'(rt_i);
      rd = 32'(rd_i);
      sh = 32'(sh_i);
      hi = imm >> 16;
      lo = imm % 65536;
      case (k)
         4'd0: push_word((rs << 21) + (rt << 16) +
                         (rd << 11) + (sh << 6) + fn, 1'b1);
         4'd1: push_word((fn << 26) + (rs << 21) +
                         (rt << 16) + lo, 1'b1);
         4'd2: begin
            if (hi == 0) begin
               push_word((13 << 26) + (rt << 16) + lo, 1'b1);
            end else if (lo == 0) begin
               push_word((15 << 26) + (rt << 16) + hi, 1'b1);
            end else begin
               push_word((15 << 26) + (rt << 16) + hi, 1'b0);
               push_word((13 << 26) + (rt << 21) +
                         (rt << 16) + lo, 1'b1);
            end
         end
         4'd3, 4'd4: begin
            if (k == 4'd3)
               w = (fn << 26) + (rs << 21) + (rt << 16) + lo;
            else
               w = (fn << 26) + (imm % (1 << 26));
`ifdef ENC_DELAY_SLOT_NOP_EN
            push_word(w, 1'b0);
            push_word(32'd0, 1'b1);
`else
            push_word(w, 1'b1);
`endif
         end
         4'd5: push_word((16 << 26) + (rt << 16) +
                         (rd << 11) + (imm % 8), 1'b1);
         4'd6: push_word((16 << 26) + (4 << 21) + (rt << 16) +
                         (rd << 11) + (imm % 8), 1'b1);
         4'd7: push_word(32'h42000018, 1'b1);
         4'd8: push_word((16 << 26) + (1 << 25) + fn, 1'b1);
         default: begin
            push_word(32'd0, 1'b1);
            m_err = 1'b1;
         end
      endcase
   endtask

   // One clock: check pre-edge handshake, then
   // post-edge outputs against the model queue.
   task automatic tick();
      logic [32:0] e;
      #1;
      chk("cmd_ready", 32'(cmd_ready),
          32'(expq.size() == 0 ||
              (instr_ready && expq.size() == 1)));
      held = 1'b0;
      if (instr_valid && instr_ready) begin
         if (expq.size() == 0) begin
            chk("extra_word", 32'(instr_valid), 32'd0);
         end else begin
            e = expq.pop_front();
            chk("data", instr_data, e[31:0]);
            chk("last", 32'(instr_last), 32'(e[32]));
         end
      end
      if (instr_valid && !instr_ready) begin
         held   = 1'b1;
         held_d = instr_data;
         held_l = instr_last;
      end
      acc = cmd_valid && cmd_ready;
      if (acc)
         model_cmd(cmd_kind, cmd_fn, cmd_rs, cmd_rt,
                   cmd_rd, cmd_shamt, cmd_imm);
      @(posedge clk);
      #1;
      chk("valid", 32'(instr_valid), 32'(expq.size() != 0));
      chk("enc_err", 32'(enc_err), 32'(m_err));
      if (held) begin
         chk("hold_data", instr_data, held_d);
         chk("hold_last", 32'(instr_last), 32'(held_l));
      end
   endtask

   task automatic set_cmd(input logic [3:0] k,
                          input logic [5:0] fn,
                          input logic [4:0] rs,
                          input logic [4:0] rt,
                          input logic [4:0] rd,
                          input logic [4:0] sh,
                          input logic [31:0] imm);
      cmd_kind  = k;
      cmd_fn    = fn;
      cmd_rs    = rs;
      cmd_rt    = rt;
      cmd_rd    = rd;
      cmd_shamt = sh;
      cmd_imm   = imm;
   endtask

   task automatic send(input logic [3:0] k,
                       input logic [5:0] fn,
                       input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic [4:0] rd,
                       input logic [4:0] sh,
                       input logic [31:0] imm);
      set_cmd(k, fn, rs, rt, rd, sh, imm);
      cmd_valid = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (acc) break;
      end
      chk("accept_timeout", 32'(acc), 32'd1);
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      expq.delete();
      m_err = 1'b0;
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_data", instr_data, 32'd0);
      chk("rst_last", 32'(instr_last), 32'd0);
      chk("rst_err", 32'(enc_err), 32'd0);
   endtask

   task automatic rand_cmd();
      int unsigned k;
      logic [31:0] imm;
      k = $urandom_range(0, 19);
      if (k == 19)
         k = $urandom_range(9, 15);
      else if (k > 8)
         k = $urandom_range(0, 8);
      imm = $urandom;
      case ($urandom_range(0, 3))
         0: imm = imm & 32'h0000ffff;
         1: imm = imm & 32'hffff0000;
         2: imm = 32'd0;
         default: ;
      endcase
      set_cmd(4'(k), 6'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom),
              5'($urandom), imm);
   endtask

   initial begin
      do_reset();
      instr_ready = 1'b1;

      send(4'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
      chk("r_word", instr_data, 32'h00221821);
      chk("r_last", 32'(instr_last), 32'd1);
      tick();

      send(4'd2, 6'd0, 5'd0, 5'd4, 5'd0, 5'd0, 32'h12345678);
      chk("li_hi", instr_data, 32'h3C041234);
      chk("li_hi_last", 32'(instr_last), 32'd0);
      tick();
      chk("li_lo", instr_data, 32'h34845678);
      chk("li_lo_last", 32'(instr_last), 32'd1);
      tick();

      send(4'd2, 6'd0, 5'd0, 5'd4, 5'd0, 5'd0, 32'h0000BEEF);
      chk("li_ori", instr_data, 32'h3404BEEF);
      chk("li_ori_last", 32'(instr_last), 32'd1);
      send(4'd2, 6'd0, 5'd0, 5'd4, 5'd0, 5'd0, 32'hABCD0000);
      chk("li_lui", instr_data, 32'h3C04ABCD);
      chk("li_lui_last", 32'(instr_last), 32'd1);
      tick();

      send(4'd3, 6'd4, 5'd1, 5'd2, 5'd0, 5'd0, 32'h00000003);
      chk("beq", instr_data, 32'h10220003);
`ifdef ENC_DELAY_SLOT_NOP_EN
      chk("beq_last", 32'(instr_last), 32'd0);
      tick();
      chk("beq_nop", instr_data, 32'd0);
      chk("beq_nop_last", 32'(instr_last), 32'd1);
`else
      chk("beq_last", 32'(instr_last), 32'd1);
`endif
      tick();

      // Back-to-back with ready high: no bubble
      for (int i = 0; i < 40; i++) begin
         rand_cmd();
         if (cmd_kind > 4'd8) cmd_kind = 4'd7;
         cmd_valid = 1'b1;
         tick();
      end
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      // Ready toggling 1/0 with steady command flow
      for (int i = 0; i < 200; i++) begin
         instr_ready = i[0];
         if (!cmd_valid || acc) rand_cmd();
         if (cmd_kind > 4'd8) cmd_kind = 4'd1;
         cmd_valid = 1'b1;
         tick();
      end
      cmd_valid = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      // Reset in the middle of a two-word LI
      send(4'd2, 6'd0, 5'd0, 5'd5, 5'd0, 5'd0, 32'hDEAD0001);
      chk("mid_li_hi", instr_data, 32'h3C05DEAD);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      expq.delete();
      m_err = 1'b0;
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      for (int i = 0; i < 3; i++) tick();

      // Unknown kind: zero word, sticky error
      send(4'hF, 6'h3f, 5'd7, 5'd7, 5'd7, 5'd7, 32'hffffffff);
      chk("unk_word", instr_data, 32'd0);
      chk("unk_last", 32'(instr_last), 32'd1);
      chk("unk_err", 32'(enc_err), 32'd1);
      for (int i = 0; i < 3; i++) tick();
      do_reset();

      // Random traffic with random backpressure
      for (int i = 0; i < 3000; i++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         cmd_valid   = ($urandom_range(0, 2) != 0);
         rand_cmd();
         tick();
      end
      cmd_valid = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
